// File: rtl/dmem_obi_bridge_pkg.sv
// Shared definitions for the data-memory to OBI bridge and its lane helper.
// Width codes, FSM state encoding and timeout counter width.
package dmem_obi_bridge_pkg;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   localparam int TIMER_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane helper: byte enables, store-data replication and
// right-alignment of load data. Width code 11 behaves as a word.
module dmem_lane_align
   import dmem_obi_bridge_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      width_i,
   input  logic [1:0]      offset_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
      case (width_i)
         W_BYTE: begin
            be_o    = 4'b0001 << offset_i;
            wdata_o = {(XLEN/8){wdata_i[7:0]}};
            rdata_o = rdata_i >> {offset_i, 3'b000};
         end
         W_HALF: begin
            be_o    = 4'b0011 << {offset_i[1], 1'b0};
            wdata_o = {(XLEN/16){wdata_i[15:0]}};
            rdata_o = rdata_i >> {offset_i[1], 4'b0000};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_obi_bridge.sv
// Bridges the single-outstanding dmem request stream onto an OBI data bus,
// with a per-transfer timeout and a sticky bus-error capture.
module dmem_obi_bridge
   import dmem_obi_bridge_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            dmem_req_i,
   input  logic            dmem_cmd_i,
   input  logic [1:0]      dmem_width_i,
   input  logic [XLEN-1:0] dmem_addr_i,
   input  logic [XLEN-1:0] dmem_wdata_i,
   output logic [XLEN-1:0] dmem_rdata_o,
   output logic            dmem_resp_o,
   output logic            obi_req_o,
   input  logic            obi_gnt_i,
   output logic            obi_we_o,
   output logic [3:0]      obi_be_o,
   output logic [XLEN-1:0] obi_addr_o,
   output logic [XLEN-1:0] obi_wdata_o,
   input  logic            obi_rvalid_i,
   input  logic [XLEN-1:0] obi_rdata_i,
   input  logic            obi_err_i,
   output logic            bus_err_o,
   output logic [XLEN-1:0] bus_err_addr_o
);

   state_e               state_q, state_d;
   logic                 cmd_q;
   logic [1:0]           width_q;
   logic [XLEN-1:0]      addr_q, wdata_q;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 orphan_q, abandon_q, bus_err_q;
   logic [XLEN-1:0]      bus_err_addr_q;
   logic                 timeout, rvalid_eff, resp, forced, capture, err_event;
   logic [3:0]           lane_be;
   logic [XLEN-1:0]      lane_wdata, lane_rdata;

   assign timeout    = (TIMEOUT_CYC != 0) && (timer_q >= TIMER_W'(TIMEOUT_CYC));
   // A response owed to an already force-completed transfer must not complete the next one.
   assign rvalid_eff = obi_rvalid_i & ~orphan_q;
   assign err_event  = forced | (resp & ~forced & obi_err_i);

   always_comb begin
      state_d   = state_q;
      obi_req_o = 1'b0;
      resp      = 1'b0;
      forced    = 1'b0;
      capture   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dmem_req_i) begin
               capture = 1'b1;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (timeout) begin
               state_d = S_DATA;
            end else begin
               obi_req_o = 1'b1;
               if (obi_gnt_i) state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rvalid_eff && !abandon_q) begin
               resp = 1'b1;
            end else if (timeout) begin
               resp   = 1'b1;
               forced = 1'b1;
            end
            if (resp) begin
               if (dmem_req_i) begin
                  capture = 1'b1;
                  state_d = S_ADDR;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      timer_d = timer_q;
      if (capture || state_q == S_IDLE) begin
         timer_d = '0;
      end else if (timer_q != '1) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         cmd_q          <= 1'b0;
         width_q        <= 2'b00;
         addr_q         <= '0;
         wdata_q        <= '0;
         orphan_q       <= 1'b0;
         abandon_q      <= 1'b0;
         bus_err_q      <= 1'b0;
         bus_err_addr_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         if (capture) begin
            cmd_q   <= dmem_cmd_i;
            width_q <= dmem_width_i;
            addr_q  <= dmem_addr_i;
            wdata_q <= dmem_wdata_i;
         end
         // An address phase that timed out was never granted, so no late response can follow.
         if (state_q == S_ADDR && timeout) begin
            abandon_q <= 1'b1;
         end else if (resp) begin
            abandon_q <= 1'b0;
         end
         if (forced && !abandon_q) begin
            orphan_q <= 1'b1;
         end else if (obi_rvalid_i) begin
            orphan_q <= 1'b0;
         end
         if (err_event) begin
            bus_err_q <= 1'b1;
            if (!bus_err_q) bus_err_addr_q <= addr_q;
         end
      end
   end

   dmem_lane_align #(
      .XLEN(XLEN)
   ) u_lane (
      .width_i  (width_q),
      .offset_i (addr_q[1:0]),
      .wdata_i  (wdata_q),
      .rdata_i  (obi_rdata_i),
      .be_o     (lane_be),
      .wdata_o  (lane_wdata),
      .rdata_o  (lane_rdata)
   );

   assign dmem_resp_o    = resp;
   assign dmem_rdata_o   = forced ? '0 : lane_rdata;
   assign obi_we_o       = cmd_q;
   assign obi_be_o       = (state_q == S_IDLE) ? 4'b0000 : lane_be;
   assign obi_addr_o     = {addr_q[XLEN-1:2], 2'b00};
   assign obi_wdata_o    = lane_wdata;
   assign bus_err_o      = bus_err_q;
   assign bus_err_addr_o = bus_err_addr_q;

   // The load/store buffer may only issue while idle or in the cycle a response completes.
   a_no_req_while_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
      dmem_req_i |-> (state_q == S_IDLE) || resp);

endmodule

// File: tb/tb_dmem_obi_bridge.sv
// Self-checking bench for dmem_obi_bridge: directed scenarios then randomized
// transfers checked against a transaction-level reference model.
module tb_dmem_obi_bridge;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmem_req, dmem_cmd;
   logic [1:0]  dmem_width;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_resp;
   logic        obi_req, obi_gnt, obi_we;
   logic [3:0]  obi_be;
   logic [31:0] obi_addr, obi_wdata;
   logic        obi_rvalid, obi_err;
   logic [31:0] obi_rdata;
   logic        bus_err;
   logic [31:0] bus_err_addr;

   int total = 0;
   int bad   = 0;
   bit          mErr = 1'b0;
   logic [31:0] mErrAddr = '0;

   typedef struct {
      bit          cmd;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gd;
      int          rd;
      bit          err;
   } txn_t;

   always #5 clk = ~clk;

   dmem_obi_bridge #(
      .XLEN(32),
      .TIMEOUT_CYC(T)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .dmem_req_i     (dmem_req),
      .dmem_cmd_i     (dmem_cmd),
      .dmem_width_i   (dmem_width),
      .dmem_addr_i    (dmem_addr),
      .dmem_wdata_i   (dmem_wdata),
      .dmem_rdata_o   (dmem_rdata),
      .dmem_resp_o    (dmem_resp),
      .obi_req_o      (obi_req),
      .obi_gnt_i      (obi_gnt),
      .obi_we_o       (obi_we),
      .obi_be_o       (obi_be),
      .obi_addr_o     (obi_addr),
      .obi_wdata_o    (obi_wdata),
      .obi_rvalid_i   (obi_rvalid),
      .obi_rdata_i    (obi_rdata),
      .obi_err_i      (obi_err),
      .bus_err_o      (bus_err),
      .bus_err_addr_o (bus_err_addr)
   );

   function automatic int sizeOf(input logic [1:0] w);
      return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [3:0] modelBe(input logic [1:0] w, input logic [31:0] a);
      logic [3:0] be;
      int off = int'(a[1:0]);
      int sz  = sizeOf(w);
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] modelWdata(input logic [1:0] w, input logic [31:0] d);
      logic [31:0] r;
      int sz = sizeOf(w);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] modelRdata(input logic [1:0] w, input logic [31:0] a, input logic [31:0] raw);
      logic [31:0] r = '0;
      int off = int'(a[1:0]);
      for (int i = 0; i < sizeOf(w); i++) r[8*i +: 8] = raw[8*(off + i) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] laneMask(input logic [1:0] w);
      return (sizeOf(w) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sizeOf(w))) - 32'd1);
   endfunction

   function automatic txn_t mk(input bit cmd, input logic [1:0] w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rdv,
                               input int gd, input int rd, input bit err);
      txn_t t;
      t.cmd = cmd; t.width = w; t.addr = a; t.wdata = wd; t.rdata = rdv;
      t.gd = gd; t.rd = rd; t.err = err;
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkErr();
      #1;
      checkOutput("bus_err", {31'd0, bus_err}, {31'd0, mErr});
      checkOutput("bus_err_addr", bus_err_addr, mErrAddr);
   endtask

   task automatic driveReq(input txn_t t);
      dmem_req   = 1'b1;
      dmem_cmd   = t.cmd;
      dmem_width = t.width;
      dmem_addr  = t.addr;
      dmem_wdata = t.wdata;
   endtask

   // One transfer; cycle 0 is the first cycle after the accepting edge.
   task automatic applyStimulus(input txn_t t, input bit preIssued, input bit chain, input txn_t nxt);
      int  respC, r, lastC;
      bit  timedAddr, granted, forced, expReq;
      timedAddr = (t.gd >= T);
      granted   = !timedAddr;
      r         = t.gd + 1 + t.rd;
      if (timedAddr) begin
         respC = T + 1; forced = 1'b1;
      end else if (r <= T) begin
         respC = r;     forced = 1'b0;
      end else begin
         respC = T;     forced = 1'b1;
      end
      lastC = (granted && r > respC) ? r : respC;
      if (!preIssued) begin
         @(negedge clk);
         driveReq(t);
      end
      @(negedge clk);
      dmem_req = 1'b0;
      for (int c = 0; c <= lastC; c++) begin
         if (c > 0) @(negedge clk);
         obi_gnt    = granted && (c == t.gd);
         obi_rvalid = granted && (c == r);
         obi_rdata  = (c == r) ? t.rdata : $urandom;
         obi_err    = (c == r) && t.err;
         if (chain && c == respC) driveReq(nxt);
         #1;
         expReq = timedAddr ? (c < T) : (c <= t.gd);
         checkOutput("obi_req", {31'd0, obi_req}, {31'd0, expReq});
         checkOutput("dmem_resp", {31'd0, dmem_resp}, {31'd0, c == respC});
         if (expReq) begin
            checkOutput("obi_addr", obi_addr, {t.addr[31:2], 2'b00});
            checkOutput("obi_be", {28'd0, obi_be}, {28'd0, modelBe(t.width, t.addr)});
            checkOutput("obi_we", {31'd0, obi_we}, {31'd0, t.cmd});
            if (t.cmd) checkOutput("obi_wdata", obi_wdata, modelWdata(t.width, t.wdata));
         end
         if (c == respC) begin
            if (forced) begin
               checkOutput("forced_rdata", dmem_rdata, 32'h0);
            end else if (!t.cmd) begin
               checkOutput("load_rdata", dmem_rdata & laneMask(t.width),
                           modelRdata(t.width, t.addr, t.rdata));
            end
            if (forced || t.err) begin
               if (!mErr) mErrAddr = t.addr;
               mErr = 1'b1;
            end
         end
      end
      if (!chain) begin
         @(negedge clk);
         obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_err = 1'b0;
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_obi_req"}, {31'd0, obi_req}, 32'd0);
      checkOutput({tag, "_dmem_resp"}, {31'd0, dmem_resp}, 32'd0);
      checkOutput({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
      checkOutput({tag, "_bus_err_addr"}, bus_err_addr, 32'd0);
      checkOutput({tag, "_obi_be"}, {28'd0, obi_be}, 32'd0);
      checkOutput({tag, "_obi_addr"}, obi_addr, 32'd0);
      checkOutput({tag, "_obi_wdata"}, obi_wdata, 32'd0);
      checkOutput({tag, "_obi_we"}, {31'd0, obi_we}, 32'd0);
   endtask

   initial begin
      txn_t a, b;
      rst_n = 1'b0; dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'b00;
      dmem_addr = '0; dmem_wdata = '0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
      obi_rdata = '0; obi_err = 1'b0;
      #1;
      checkIdleZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      a = mk(1'b0, 2'b10, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
      applyStimulus(a, 1'b0, 1'b0, a);
      a = mk(1'b1, 2'b00, 32'h0000_2003, 32'h1234_56A5, 32'h0, 1, 0, 1'b0);
      applyStimulus(a, 1'b0, 1'b0, a);
      a = mk(1'b0, 2'b01, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 3, 0, 1'b0);
      applyStimulus(a, 1'b0, 1'b0, a);

      a = mk(1'b0, 2'b10, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0);
      b = mk(1'b1, 2'b01, 32'h0000_4006, 32'hCAFE_9876, 32'h0, 0, 1, 1'b0);
      applyStimulus(a, 1'b0, 1'b1, b);
      applyStimulus(b, 1'b1, 1'b0, b);
      checkErr();

      a = mk(1'b0, 2'b10, 32'h0000_5004, 32'h0, 32'h1111_2222, 0, 5, 1'b0);
      applyStimulus(a, 1'b0, 1'b0, a);
      checkErr();
      a = mk(1'b0, 2'b10, 32'h0000_6000, 32'h0, 32'h3333_4444, 1, 0, 1'b1);
      applyStimulus(a, 1'b0, 1'b0, a);
      a = mk(1'b1, 2'b00, 32'h0000_7001, 32'h0000_0077, 32'h0, 5, 0, 1'b0);
      applyStimulus(a, 1'b0, 1'b0, a);
      checkErr();

      @(negedge clk);
      driveReq(mk(1'b1, 2'b10, 32'h0000_8008, 32'h5555_AAAA, 32'h0, 0, 0, 1'b0));
      @(negedge clk);
      dmem_req = 1'b0; obi_gnt = 1'b1;
      @(negedge clk);
      obi_gnt = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkIdleZero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      mErr = 1'b0; mErrAddr = '0;

      for (int n = 0; n < 60; n++) begin
         logic [1:0]  w;
         logic [31:0] ad;
         w  = 2'($urandom_range(0, 3));
         ad = $urandom & ~(32'(sizeOf(w)) - 32'd1);
         a  = mk(1'($urandom_range(0, 1)), w, ad, $urandom, $urandom,
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 7) == 0);
         applyStimulus(a, 1'b0, 1'b0, a);
         checkErr();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
